dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder for the MEM stage of the pipelined MIPS core.
- The pipeline acts as the initiator: it issues load/store requests carrying address, write data and access size.
- This block accepts each request, inserts a configurable number of wait states, performs a byte-lane-correct word-array access, and returns one ready pulse with read data or an alignment error.
- Stall logic uses busy_o to hold the pipeline while an access is outstanding.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array; must be a power of two.
- LATENCY, 1, wait cycles inserted before the response; legal range 0..7.

Ports:
- clk  input  1  core clock; everything updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- req_i  input  1  request valid; sampled only in IDLE.
- we_i  input  1  1 = store, 0 = load.
- size_i  input  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- uns_i  input  1  zero-extend loads; used only when DMEM_LOADEXT_EN is defined.
- addr_i  input  32  byte address.
- wdata_i  input  32  store data, right-justified: byte in [7:0], half in [15:0].
- rdata_o  output  32  load result; valid while ready_o=1, held afterwards.
- ready_o  output  1  one-cycle response pulse.
- addr_err_o  output  1  misaligned or illegal-size flag; pulses together with ready_o.
- busy_o  output  1  high whenever state != IDLE.

Behaviour:
- Reset: synchronous, active-high, clock is clk.
  - state=IDLE; rdata_o=0, ready_o=0, addr_err_o=0, busy_o=0.
  - Wait counter cleared; any pending request, including an uncommitted store, is discarded.
  - Array contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
  - IDLE, req_i=1: latch we/size/uns/addr/wdata. Go to WAIT if LATENCY>0 (counter=LATENCY-1), else go to RESP.
  - IDLE, req_i=0: stay in IDLE.
  - WAIT: decrement the counter. Go to RESP when the counter is 0.
  - RESP: ready_o=1 for exactly this cycle, then return to IDLE.
- Latency: if the request is accepted in cycle T, ready_o is high in cycle T+LATENCY+1.
  - Earliest next accept is T+LATENCY+2, so throughput is one access per LATENCY+2 cycles.
- req_i while busy_o=1 is ignored. No queueing; the initiator must hold or re-present the request.
- Word index is addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo the array size.
- Alignment:
  - Half requires addr[0]=0; word requires addr[1:0]=00; size 11 is always an error.
  - On error: ready_o=1 and addr_err_o=1 in RESP, no array write, rdata_o=0.
- Stores, committed at the RESP clock edge:
  - Byte: wdata[7:0] written to lane addr[1:0].
  - Half: wdata[15:0] written to lanes {addr[1],0} and {addr[1],1}.
  - Word: all four lanes written.
  - Unselected lanes are unchanged. rdata_o is unchanged by a store.
- Loads: array read in RESP. rdata_o is registered, so it changes only on a load response or reset.
- Byte lane n maps to bits [8n+7:8n] (little-endian lanes).

Optional Feature:
- Macro DMEM_LOADEXT_EN.
- Defined: rdata_o is the extracted field, right-justified.
  - Byte: lane addr[1:0]. Half: lanes selected by addr[1].
  - Sign-extended when uns_i=0, zero-extended when uns_i=1. Word loads are unaffected.
- Undefined: rdata_o is always the raw aligned 32-bit word. uns_i is ignored; sub-word extraction is done by the pipeline.

Test Plan:
- Reset, then LATENCY=1. Word store 0xDEADBEEF to 0x10, accepted in cycle T: ready_o high at T+2 only, busy_o high T+1..T+2. Word load from 0x10 returns 0xDEADBEEF.
- Byte store 0xAA to 0x11, then word load 0x10: returns 0xDEADAAEF. Half store 0x1234 to 0x12, then word load: returns 0x1234AAEF.
- Misaligned accesses: word load at 0x13, half store at 0x15, size=11 at 0x20. Each gives ready_o=1, addr_err_o=1, rdata_o=0; a follow-up word load at 0x14 shows no modification.
- Wrap: DEPTH_WORDS=1024, word store 0x5 to 0x1000, then word load 0x0 returns 0x5. req_i held high during WAIT is accepted only once, with a second accept no earlier than T+3.
- Reset mid-op: store 0xFFFFFFFF to 0x20 with LATENCY=3, rst asserted in the first WAIT cycle. Then: ready_o never pulses, busy_o=0 the cycle after rst, and a later load of 0x20 returns its prior value.
- With DMEM_LOADEXT_EN, word at 0x30 = 0x80FF7F01:
  - Byte load 0x32, uns=0 → 0xFFFFFFFF; uns=1 → 0x000000FF.
  - Half load 0x32, uns=0 → 0xFFFF80FF.
  - Without the macro, the same loads return 0x80FF7F01.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the MEM stage of the pipelined MIPS core.
// Accepts one load/store request at a time, waits LATENCY cycles, performs a
// byte-lane-correct access to a DEPTH_WORDS x 32 array and pulses ready_o once.
// Optional feature macro: DMEM_LOADEXT_EN (sub-word load extraction with
// sign/zero extension). Without it, loads return the raw aligned word.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        ready_o,
    output logic        addr_err_o,
    output logic        busy_o
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [2:0] CNT_INIT = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t             state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [1:0]         size_q, size_d;
    logic [IDX_W+1:0]   addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               err_q, err_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               ready_q, ready_d;
    logic               addr_err_q, addr_err_d;
    logic               busy_q, busy_d;

    logic [31:0]        mem [DEPTH_WORDS];

    logic [IDX_W-1:0]   ld_idx;
    logic [31:0]        ld_word;
    logic [31:0]        ld_data;
    logic [3:0]         wr_be;
    logic [31:0]        wr_lanes;

    // Upper address bits only select aliases of the same word.
    logic [31-IDX_W-2:0] unused_addr_hi;
    assign unused_addr_hi = addr_i[31:IDX_W+2];

`ifdef DMEM_LOADEXT_EN
    logic               uns_q, uns_d;
    logic [1:0]         ld_lane;
    logic [1:0]         ld_size;
    logic               ld_uns;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
`else
    // Extension is done by the pipeline in this build.
    logic               unused_uns;
    assign unused_uns = uns_i;
`endif

    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = a[0];
            2'b10:   misaligned = |a;
            default: misaligned = 1'b1;
        endcase
    endfunction

    // Load path: read the addressed word from whichever request is about to respond.
    always_comb begin
        ld_idx  = (state_q == S_IDLE) ? addr_i[IDX_W+1:2] : addr_q[IDX_W+1:2];
        ld_word = mem[ld_idx];
`ifdef DMEM_LOADEXT_EN
        ld_lane = (state_q == S_IDLE) ? addr_i[1:0] : addr_q[1:0];
        ld_size = (state_q == S_IDLE) ? size_i : size_q;
        ld_uns  = (state_q == S_IDLE) ? uns_i : uns_q;
        ld_byte = ld_word[{ld_lane, 3'b000} +: 8];
        ld_half = ld_lane[1] ? ld_word[31:16] : ld_word[15:0];
        case (ld_size)
            2'b00:   ld_data = ld_uns ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = ld_uns ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data = ld_word;
        endcase
`else
        ld_data = ld_word;
`endif
    end

    // Next-state, request capture and registered response outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a value unassigned (no latches).
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        size_d     = size_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        ready_d    = 1'b0;
        addr_err_d = 1'b0;
`ifdef DMEM_LOADEXT_EN
        uns_d      = uns_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    size_d  = size_i;
                    addr_d  = addr_i[IDX_W+1:0];
                    wdata_d = wdata_i;
                    err_d   = misaligned(size_i, addr_i[1:0]);
`ifdef DMEM_LOADEXT_EN
                    uns_d   = uns_i;
`endif
                    if (LATENCY > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd0) state_d = S_RESP;
                else               cnt_d   = cnt_q - 3'd1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_RESP) begin
            ready_d    = 1'b1;
            addr_err_d = err_d;
            if (err_d)      rdata_d = 32'd0;
            else if (!we_d) rdata_d = ld_data;
        end
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            err_q      <= 1'b0;
            rdata_q    <= 32'd0;
            ready_q    <= 1'b0;
            addr_err_q <= 1'b0;
            busy_q     <= 1'b0;
`ifdef DMEM_LOADEXT_EN
            uns_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            addr_err_q <= addr_err_d;
            busy_q     <= busy_d;
`ifdef DMEM_LOADEXT_EN
            uns_q      <= uns_d;
`endif
        end
    end

    // Store byte enables and lane-replicated write data.
    always_comb begin
        wr_be    = 4'b0000;
        wr_lanes = wdata_q;
        case (size_q)
            2'b00: begin
                wr_be    = 4'b0001 << addr_q[1:0];
                wr_lanes = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                wr_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{wdata_q[15:0]}};
            end
            2'b10:   wr_be = 4'b1111;
            default: wr_be = 4'b0000;
        endcase
    end

    // Store commit at the RESP edge; a reset on that edge discards it.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; contents survive rst and map onto plain RAM.
        if (!rst && state_q == S_RESP && we_q && !err_q) begin
            for (int n = 0; n < 4; n++) begin
                if (wr_be[n]) mem[addr_q[IDX_W+1:2]][8*n +: 8] <= wr_lanes[8*n +: 8];
            end
        end
    end

    assign rdata_o    = rdata_q;
    assign ready_o    = ready_q;
    assign addr_err_o = addr_err_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with LATENCY=1, one with LATENCY=3.
module tb_dmem_responder;

    localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_X = 2'b11;

    logic        clk = 1'b0;
    logic        rst, rst3, req, req3, we, uns;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [31:0] rdata1, rdata3;
    logic        ready1, ready3, err1, err3, busy1, busy3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut (
        .clk(clk), .rst(rst), .req_i(req), .we_i(we), .size_i(size), .uns_i(uns),
        .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata1), .ready_o(ready1),
        .addr_err_o(err1), .busy_o(busy1)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst3), .req_i(req3), .we_i(we), .size_i(size), .uns_i(uns),
        .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata3), .ready_o(ready3),
        .addr_err_o(err3), .busy_o(busy3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One request; returns at the negedge of the ready cycle (or after a 20-cycle bound).
    task automatic access(input bit sel3, input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat,
                          output logic busy_first);
        @(negedge clk);
        we = w; size = sz; uns = u; addr = a; wdata = wd;
        if (sel3) req3 = 1'b1; else req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0; req3 = 1'b0;
        lat = 1;
        busy_first = sel3 ? busy3 : busy1;
        while (!(sel3 ? ready3 : ready1) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = sel3 ? rdata3 : rdata1;
        er = sel3 ? err3 : err1;
    endtask

    task automatic do_load(input string tag, input bit sel3, input logic [1:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] exp_rd, input logic exp_err);
        logic [31:0] rd; logic er, bf; int lat;
        access(sel3, 1'b0, sz, u, a, 32'h0, rd, er, lat, bf);
        check({tag, "_lat"}, 32'(lat), sel3 ? 32'd4 : 32'd2);
        check({tag, "_err"}, {31'b0, er}, {31'b0, exp_err});
        check({tag, "_rd"}, rd, exp_rd);
    endtask

    task automatic do_store(input string tag, input bit sel3, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic exp_err, input logic [31:0] exp_hold);
        logic [31:0] rd; logic er, bf; int lat;
        access(sel3, 1'b1, sz, 1'b0, a, wd, rd, er, lat, bf);
        check({tag, "_lat"}, 32'(lat), sel3 ? 32'd4 : 32'd2);
        check({tag, "_err"}, {31'b0, er}, {31'b0, exp_err});
        check({tag, "_rd"}, rd, exp_hold);
    endtask

    initial begin
        logic [31:0] rd; logic er, bf; int lat; int pulses;
        logic exp_ready [1:6];
        rst = 1'b1; rst3 = 1'b1; req = 1'b0; req3 = 1'b0;
        we = 1'b0; uns = 1'b0; size = SZ_W; addr = 32'h0; wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; rst3 = 1'b0;
        check("rst_rdata", rdata1, 32'h0);
        check("rst_ready", {31'b0, ready1}, 32'h0);
        check("rst_err",   {31'b0, err1},   32'h0);
        check("rst_busy",  {31'b0, busy1},  32'h0);
        check("rst3_busy", {31'b0, busy3},  32'h0);

        // Word store timing: ready at T+2 only, busy at T+1 and T+2.
        access(1'b0, 1'b1, SZ_W, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat, bf);
        check("st10_lat",   32'(lat), 32'd2);
        check("st10_busy1", {31'b0, bf}, 32'h1);
        check("st10_busy2", {31'b0, busy1}, 32'h1);
        check("st10_err",   {31'b0, er}, 32'h0);
        check("st10_rd",    rd, 32'h0);
        @(negedge clk);
        check("st10_ready3", {31'b0, ready1}, 32'h0);
        check("st10_busy3",  {31'b0, busy1},  32'h0);

        do_load ("ld10a", 1'b0, SZ_W, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
        do_store("stb11", 1'b0, SZ_B, 32'h11, 32'h000000AA, 1'b0, 32'hDEADBEEF);
        do_load ("ld10b", 1'b0, SZ_W, 1'b0, 32'h10, 32'hDEADAAEF, 1'b0);
        do_store("sth12", 1'b0, SZ_H, 32'h12, 32'h00001234, 1'b0, 32'hDEADAAEF);
        do_load ("ld10c", 1'b0, SZ_W, 1'b0, 32'h10, 32'h1234AAEF, 1'b0);

        // Misalignment and illegal size.
        do_store("st14",  1'b0, SZ_W, 32'h14, 32'h11223344, 1'b0, 32'h1234AAEF);
        do_store("st20",  1'b0, SZ_W, 32'h20, 32'hCAFEF00D, 1'b0, 32'h1234AAEF);
        do_load ("ldw13", 1'b0, SZ_W, 1'b0, 32'h13, 32'h0, 1'b1);
        do_store("sth15", 1'b0, SZ_H, 32'h15, 32'h0000FFFF, 1'b1, 32'h0);
        do_load ("ld14",  1'b0, SZ_W, 1'b0, 32'h14, 32'h11223344, 1'b0);
        do_store("stx20", 1'b0, SZ_X, 32'h20, 32'hFFFFFFFF, 1'b1, 32'h0);
        do_load ("ld20",  1'b0, SZ_W, 1'b0, 32'h20, 32'hCAFEF00D, 1'b0);

        // Address wrap.
        do_store("st1000", 1'b0, SZ_W, 32'h1000, 32'h00000005, 1'b0, 32'hCAFEF00D);
        do_load ("ld0",    1'b0, SZ_W, 1'b0, 32'h0, 32'h00000005, 1'b0);

        // req held high: accepts at T and T+3, ready at T+2 and T+5.
        exp_ready[1] = 1'b0; exp_ready[2] = 1'b1; exp_ready[3] = 1'b0;
        exp_ready[4] = 1'b0; exp_ready[5] = 1'b1; exp_ready[6] = 1'b0;
        @(negedge clk);
        we = 1'b0; size = SZ_W; addr = 32'h0; req = 1'b1;
        @(posedge clk);
        for (int off = 1; off <= 6; off++) begin
            @(negedge clk);
            if (off == 6) req = 1'b0;
            check($sformatf("hold_ready_t%0d", off), {31'b0, ready1}, {31'b0, exp_ready[off]});
            if (off == 3) check("hold_busy_t3", {31'b0, busy1}, 32'h0);
            if (off == 5) check("hold_rd_t5", rdata1, 32'h5);
        end
        @(negedge clk);
        check("hold_busy_t7", {31'b0, busy1}, 32'h0);

        // Reset during the first WAIT cycle discards the store (LATENCY=3 instance).
        do_store("l3_st20", 1'b1, SZ_W, 32'h20, 32'h0BADCAFE, 1'b0, 32'h0);
        @(negedge clk);
        we = 1'b1; size = SZ_W; addr = 32'h20; wdata = 32'hFFFFFFFF; req3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req3 = 1'b0; rst3 = 1'b1;
        check("midrst_busy_wait", {31'b0, busy3}, 32'h1);
        @(negedge clk);
        rst3 = 1'b0;
        check("midrst_busy_after", {31'b0, busy3}, 32'h0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (ready3) pulses++;
            @(negedge clk);
        end
        check("midrst_no_ready", 32'(pulses), 32'd0);
        do_load("l3_ld20", 1'b1, SZ_W, 1'b0, 32'h20, 32'h0BADCAFE, 1'b0);

        // Sub-word load extraction.
        do_store("st30", 1'b0, SZ_W, 32'h30, 32'h80FF7F01, 1'b0, 32'h5);
`ifdef DMEM_LOADEXT_EN
        do_load("ldb32s", 1'b0, SZ_B, 1'b0, 32'h32, 32'hFFFFFFFF, 1'b0);
        do_load("ldb32u", 1'b0, SZ_B, 1'b1, 32'h32, 32'h000000FF, 1'b0);
        do_load("ldh32s", 1'b0, SZ_H, 1'b0, 32'h32, 32'hFFFF80FF, 1'b0);
        do_load("ldb31s", 1'b0, SZ_B, 1'b0, 32'h31, 32'h0000007F, 1'b0);
        do_load("ldh30u", 1'b0, SZ_H, 1'b1, 32'h30, 32'h00007F01, 1'b0);
`else
        do_load("ldb32s", 1'b0, SZ_B, 1'b0, 32'h32, 32'h80FF7F01, 1'b0);
        do_load("ldb32u", 1'b0, SZ_B, 1'b1, 32'h32, 32'h80FF7F01, 1'b0);
        do_load("ldh32s", 1'b0, SZ_H, 1'b0, 32'h32, 32'h80FF7F01, 1'b0);
        do_load("ldb31s", 1'b0, SZ_B, 1'b0, 32'h31, 32'h80FF7F01, 1'b0);
        do_load("ldh30u", 1'b0, SZ_H, 1'b1, 32'h30, 32'h80FF7F01, 1'b0);
`endif
        do_load("ldw30", 1'b0, SZ_W, 1'b1, 32'h30, 32'h80FF7F01, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
